// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// writeback_queue : FIFO-buffered register-file writeback with two forwarding
//                   lookups over pending (queued or output-stage) writes.
// Revision 1.0
// ============================================================================
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InRegister,
  input  logic [31:0]   InData,
  output logic          RegWrite,
  output logic [4:0]    WriteRegister,
  output logic [31:0]   WriteData,
  input  logic [4:0]    ReadRegister1,
  input  logic [4:0]    ReadRegister2,
  output logic          Fwd1Hit,
  output logic [31:0]   Fwd1Data,
  output logic          Fwd2Hit,
  output logic [31:0]   Fwd2Data,
  output logic [CW-1:0] Count
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [4:0]    r_reg  [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_wr_en;
  logic [4:0]    r_wr_reg;
  logic [31:0]   r_wr_data;

  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_hit1;
  logic          w_hit2;
  logic [31:0]   w_dat1;
  logic [31:0]   w_dat2;

  // Writes to $0 complete the handshake but are never stored.
  assign w_ready  = Reset_n && (r_count != C_FULL);
  assign w_accept = InValid && w_ready;
  assign w_push   = w_accept && (InRegister != 5'd0);
  assign w_pop    = (r_count != '0);

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_reg[r_tail]  <= InRegister;
      r_data[r_tail] <= InData;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head    <= r_head + AW'(1);
        r_wr_en   <= 1'b1;
        r_wr_reg  <= r_reg[r_head];
        r_wr_data <= r_data[r_head];
      end else begin
        r_wr_en   <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_dat1 = '0;
    w_hit2 = 1'b0;
    w_dat2 = '0;
    if (r_wr_en && (r_wr_reg == ReadRegister1)) begin
      w_hit1 = 1'b1;
      w_dat1 = r_wr_data;
    end
    if (r_wr_en && (r_wr_reg == ReadRegister2)) begin
      w_hit2 = 1'b1;
      w_dat2 = r_wr_data;
    end
    // Walk oldest to youngest so the entry nearest the tail wins.
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        if (r_reg[r_head + AW'(k)] == ReadRegister1) begin
          w_hit1 = 1'b1;
          w_dat1 = r_data[r_head + AW'(k)];
        end
        if (r_reg[r_head + AW'(k)] == ReadRegister2) begin
          w_hit2 = 1'b1;
          w_dat2 = r_data[r_head + AW'(k)];
        end
      end
    end
    if (ReadRegister1 == 5'd0) begin
      w_hit1 = 1'b0;
      w_dat1 = '0;
    end
    if (ReadRegister2 == 5'd0) begin
      w_hit2 = 1'b0;
      w_dat2 = '0;
    end
  end

  assign InReady       = w_ready;
  assign RegWrite      = r_wr_en;
  assign WriteRegister = r_wr_reg;
  assign WriteData     = r_wr_data;
  assign Fwd1Hit       = w_hit1;
  assign Fwd1Data      = w_dat1;
  assign Fwd2Hit       = w_hit2;
  assign Fwd2Data      = w_dat2;
  assign Count         = r_count;

endmodule
`default_nettype wire
